// File: rtl/param_dual_port_ram.sv
// True dual-port RAM with a shared array, selectable same-port read-during-write
// behaviour, same-address write collision flag and an optional post-reset zero-fill.
module param_dual_port_ram #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  port_en_0,
   input  logic                  wr_en_0,
   input  logic [ADDR_WIDTH-1:0] addr_in_p0,
   input  logic [DATA_WIDTH-1:0] data_in_0,
   input  logic                  port_en_1,
   input  logic                  wr_en_1,
   input  logic [ADDR_WIDTH-1:0] addr_in_p1,
   input  logic [DATA_WIDTH-1:0] data_in_1,
   output logic [DATA_WIDTH-1:0] data_output_0,
   output logic [DATA_WIDTH-1:0] data_output_1,
   output logic                  busy,
   output logic                  collision
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                state_reg;
   logic [ADDR_WIDTH:0]   clear_count_reg;
   logic                  collision_reg;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [1:0]            port_en;
   logic [1:0]            wr_en;
   logic [1:0]            access;
   logic [1:0]            write;
   logic [ADDR_WIDTH-1:0] addr [2];
   logic [DATA_WIDTH-1:0] din [2];

   assign port_en = {port_en_1, port_en_0};
   assign wr_en   = {wr_en_1, wr_en_0};
   assign addr    = '{addr_in_p0, addr_in_p1};
   assign din     = '{data_in_0, data_in_1};

   assign busy    = (state_reg == CLEAR);
   // User traffic is locked out both while clearing and on a reset edge.
   assign access  = port_en & {2{~busy & ~reset}};
   assign write   = access & wr_en;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg       <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         clear_count_reg <= '0;
      end else if (state_reg == CLEAR) begin
         clear_count_reg <= clear_count_reg + 1'b1;
         if (clear_count_reg == LAST_ADDR) begin
            state_reg <= IDLE;
         end
      end
   end

   // Port 0 is written last so it wins a same-address dual write.
   always_ff @(posedge clock) begin
      if (busy) begin
         mem[clear_count_reg[ADDR_WIDTH-1:0]] <= '0;
      end else begin
         if (write[1]) begin
            mem[addr[1]] <= din[1];
         end
         if (write[0]) begin
            mem[addr[0]] <= din[0];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         logic [DATA_WIDTH-1:0] rd_data_reg;

         always_ff @(posedge clock) begin
            if (reset) begin
               rd_data_reg <= '0;
            end else if (access[gi]) begin
               rd_data_reg <= (write[gi] && (RDW_MODE != 0)) ? din[gi] : mem[addr[gi]];
            end
         end
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         collision_reg <= 1'b0;
      end else begin
         collision_reg <= write[0] && write[1] && (addr_in_p0 == addr_in_p1);
      end
   end

   assign data_output_0 = g_port[0].rd_data_reg;
   assign data_output_1 = g_port[1].rd_data_reg;
   assign collision     = collision_reg;

endmodule

// File: tb/tb_param_dual_port_ram.sv
// Bench for param_dual_port_ram: a read-first and a write-first instance share
// stimulus; a 16x64 no-clear instance covers the wide/no-clear configuration.
module tb_param_dual_port_ram;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en0, wr0, en1, wr1;
   logic [3:0] a0, a1;
   logic [7:0] d0, d1;
   logic [7:0] qa0, qa1, qb0, qb1;
   logic       busy_a, busy_b, coll_a, coll_b;

   logic        c_en0, c_wr0, c_en1, c_wr1;
   logic [5:0]  c_a0, c_a1;
   logic [15:0] c_d0, c_d1, c_q0, c_q1;
   logic        busy_c, coll_c;
   logic        busy_c_seen = 1'b0;

   int checks = 0;
   int errors = 0;

   param_dual_port_ram #(.RDW_MODE(0)) dut_a (
      .clock(clk), .reset(rst),
      .port_en_0(en0), .wr_en_0(wr0), .addr_in_p0(a0), .data_in_0(d0),
      .port_en_1(en1), .wr_en_1(wr1), .addr_in_p1(a1), .data_in_1(d1),
      .data_output_0(qa0), .data_output_1(qa1), .busy(busy_a), .collision(coll_a));

   param_dual_port_ram #(.RDW_MODE(1)) dut_b (
      .clock(clk), .reset(rst),
      .port_en_0(en0), .wr_en_0(wr0), .addr_in_p0(a0), .data_in_0(d0),
      .port_en_1(en1), .wr_en_1(wr1), .addr_in_p1(a1), .data_in_1(d1),
      .data_output_0(qb0), .data_output_1(qb1), .busy(busy_b), .collision(coll_b));

   param_dual_port_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .CLEAR_ON_RESET(0)) dut_c (
      .clock(clk), .reset(rst),
      .port_en_0(c_en0), .wr_en_0(c_wr0), .addr_in_p0(c_a0), .data_in_0(c_d0),
      .port_en_1(c_en1), .wr_en_1(c_wr1), .addr_in_p1(c_a1), .data_in_1(c_d1),
      .data_output_0(c_q0), .data_output_1(c_q1), .busy(busy_c), .collision(coll_c));

   always @(negedge clk) if (busy_c === 1'b1) busy_c_seen = 1'b1;

   typedef struct {
      logic       en0, wr0;
      logic [3:0] a0;
      logic [7:0] d0;
      logic       en1, wr1;
      logic [3:0] a1;
      logic [7:0] d1;
      logic [7:0] e0a, e0b, e1a, e1b;
      logic       ec;
   } vec_t;

   vec_t tab[$];
   vec_t sb[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic void add(input logic e0, input logic w0, input logic [3:0] ad0,
                               input logic [7:0] dd0, input logic e1, input logic w1,
                               input logic [3:0] ad1, input logic [7:0] dd1,
                               input logic [7:0] x0a, input logic [7:0] x0b,
                               input logic [7:0] x1a, input logic [7:0] x1b, input logic xc);
      vec_t v;
      v.en0 = e0; v.wr0 = w0; v.a0 = ad0; v.d0 = dd0;
      v.en1 = e1; v.wr1 = w1; v.a1 = ad1; v.d1 = dd1;
      v.e0a = x0a; v.e0b = x0b; v.e1a = x1a; v.e1b = x1b; v.ec = xc;
      tab.push_back(v);
   endfunction

   task automatic idle_inputs();
      en0 = 0; wr0 = 0; a0 = '0; d0 = '0;
      en1 = 0; wr1 = 0; a1 = '0; d1 = '0;
   endtask

   // Called at a falling edge: drive, queue the expectation, compare after the edge.
   task automatic apply(input int lo, input int hi);
      vec_t v;
      for (int i = lo; i < hi; i++) begin
         v = tab[i];
         en0 = v.en0; wr0 = v.wr0; a0 = v.a0; d0 = v.d0;
         en1 = v.en1; wr1 = v.wr1; a1 = v.a1; d1 = v.d1;
         sb.push_back(v);
         @(posedge clk);
         #1;
         v = sb.pop_front();
         $display("vec %0d: p0 en=%0b wr=%0b a=%h d=%h | p1 en=%0b wr=%0b a=%h d=%h | q=%h %h %h %h coll=%0b %0b",
                  i, v.en0, v.wr0, v.a0, v.d0, v.en1, v.wr1, v.a1, v.d1, qa0, qa1, qb0, qb1, coll_a, coll_b);
         check($sformatf("v%0d_a_out0", i), 16'(qa0), 16'(v.e0a));
         check($sformatf("v%0d_a_out1", i), 16'(qa1), 16'(v.e1a));
         check($sformatf("v%0d_b_out0", i), 16'(qb0), 16'(v.e0b));
         check($sformatf("v%0d_b_out1", i), 16'(qb1), 16'(v.e1b));
         check($sformatf("v%0d_a_coll", i), 16'(coll_a), 16'(v.ec));
         check($sformatf("v%0d_b_coll", i), 16'(coll_b), 16'(v.ec));
         @(negedge clk);
      end
      idle_inputs();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int seg2;

      // Table: zero-fill readback, fill 1..16, cross-port readback, corner cases.
      for (int i = 0; i < 16; i++)
         add(1, 0, 4'(i), 8'h00, 1, 0, 4'(i), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
      for (int i = 0; i < 16; i++)
         add(1, 1, 4'(i), 8'(i + 1), 0, 0, 4'h0, 8'h00, 8'h00, 8'(i + 1), 8'h00, 8'h00, 0);
      for (int i = 0; i < 16; i++)
         add(0, 0, 4'h0, 8'h00, 1, 0, 4'(i), 8'h00, 8'h00, 8'h10, 8'(i + 1), 8'(i + 1), 0);
      add(1, 1, 4'd3, 8'hAA, 1, 1, 4'd3, 8'h55, 8'h04, 8'hAA, 8'h04, 8'h55, 1);
      add(1, 0, 4'd3, 8'h00, 1, 0, 4'd3, 8'h00, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 0);
      add(1, 1, 4'd5, 8'h11, 0, 0, 4'd0, 8'h00, 8'h06, 8'h11, 8'hAA, 8'hAA, 0);
      add(1, 1, 4'd5, 8'h22, 1, 0, 4'd5, 8'h00, 8'h11, 8'h22, 8'h11, 8'h11, 0);
      add(1, 0, 4'd5, 8'h00, 1, 0, 4'd5, 8'h00, 8'h22, 8'h22, 8'h22, 8'h22, 0);
      add(1, 0, 4'd9, 8'h00, 1, 1, 4'd9, 8'h77, 8'h0A, 8'h0A, 8'h0A, 8'h77, 0);
      add(1, 0, 4'd9, 8'h00, 0, 0, 4'd0, 8'h00, 8'h77, 8'h77, 8'h0A, 8'h77, 0);
      add(1, 1, 4'd1, 8'h33, 1, 1, 4'd2, 8'h44, 8'h02, 8'h33, 8'h03, 8'h44, 0);
      add(1, 0, 4'd2, 8'h00, 1, 0, 4'd1, 8'h00, 8'h44, 8'h44, 8'h33, 8'h33, 0);
      seg2 = tab.size();
      // After the interrupted clear: first access, dropped write at 0, cleared words.
      add(1, 1, 4'd6, 8'h99, 1, 0, 4'd0, 8'h00, 8'h00, 8'h99, 8'h00, 8'h00, 0);
      add(1, 0, 4'd15, 8'h00, 1, 0, 4'd6, 8'h00, 8'h00, 8'h00, 8'h99, 8'h99, 0);
      add(1, 0, 4'd8, 8'h00, 1, 0, 4'd3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);

      idle_inputs();
      c_en0 = 0; c_wr0 = 0; c_a0 = '0; c_d0 = '0;
      c_en1 = 0; c_wr1 = 0; c_a1 = '0; c_d1 = '0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      $display("reset: q=%h %h busy=%0b %0b %0b", qa0, qa1, busy_a, busy_b, busy_c);
      check("rst_a_out0", 16'(qa0), 16'h0);
      check("rst_a_out1", 16'(qa1), 16'h0);
      check("rst_a_coll", 16'(coll_a), 16'h0);
      check("rst_a_busy", 16'(busy_a), 16'h1);
      check("rst_c_busy", 16'(busy_c), 16'h0);
      check("rst_c_out1", c_q1, 16'h0);

      @(negedge clk);
      rst = 0;
      cnt = 0;
      while (busy_a === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      $display("clear: busy cycles=%0d", cnt);
      check("clear_busy_cycles", 16'(cnt), 16'd16);
      check("clear_b_busy_done", 16'(busy_b), 16'h0);

      // Wide no-clear instance: write top address, read back on the other port.
      c_en0 = 1; c_wr0 = 1; c_a0 = 6'd63; c_d0 = 16'hBEEF;
      @(negedge clk);
      c_en0 = 0; c_wr0 = 0;
      c_en1 = 1; c_a1 = 6'd63;
      @(posedge clk);
      #1;
      $display("wide: read addr 63 -> %h", c_q1);
      check("wide_read_p1", c_q1, 16'hBEEF);
      @(negedge clk);
      c_en1 = 0;

      apply(0, seg2);

      // Reset pulse, then another pulse at clear cycle 7 restarts the clear.
      rst = 1;
      @(posedge clk);
      #1;
      $display("reset pulse: q=%h %h", qa0, qb0);
      check("pulse_a_out0", 16'(qa0), 16'h0);
      check("pulse_b_out1", 16'(qb1), 16'h0);
      @(negedge clk);
      rst = 0;
      repeat (7) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
      cnt = 0;
      while (busy_a === 1'b1 && cnt < 40) begin
         cnt++;
         if (cnt == 16) begin
            en0 = 1; wr0 = 1; a0 = 4'd0; d0 = 8'h5A;
         end else begin
            idle_inputs();
         end
         @(negedge clk);
      end
      idle_inputs();
      $display("restart clear: busy cycles=%0d", cnt);
      check("restart_busy_cycles", 16'(cnt), 16'd16);

      apply(seg2, tab.size());

      c_en0 = 1; c_a0 = 6'd63;
      @(posedge clk);
      #1;
      $display("wide: read addr 63 after reset -> %h", c_q0);
      check("wide_kept_over_reset", c_q0, 16'hBEEF);
      @(negedge clk);
      c_en0 = 0;
      check("wide_busy_never", 16'(busy_c_seen), 16'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/param_dual_port_ram.md
PARAM_DUAL_PORT_RAM -- requirements
Module: param_dual_port_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter RDW_MODE, default 0, SHALL select same-port read-during-write behaviour: 0 = read-first (old data), 1 = write-first (new data).
REQ-004 Parameter CLEAR_ON_RESET, default 1, SHALL enable zero-fill of all locations after reset.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port list SHALL be as follows (name, direction, width, meaning):
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- port_en_0  in  1  port 0 enable.
- wr_en_0  in  1  port 0 write (1) / read (0).
- addr_in_p0  in  ADDR_WIDTH  port 0 address.
- data_in_0  in  DATA_WIDTH  port 0 write data.
- port_en_1  in  1  port 1 enable.
- wr_en_1  in  1  port 1 write (1) / read (0).
- addr_in_p1  in  ADDR_WIDTH  port 1 address.
- data_in_1  in  DATA_WIDTH  port 1 write data.
- data_output_0  out  DATA_WIDTH  port 0 registered read data.
- data_output_1  out  DATA_WIDTH  port 1 registered read data.
- busy  out  1  high while the clear sequencer runs; ports are ignored.
- collision  out  1  one-cycle pulse on a same-address dual write.

Function
REQ-007 Both ports SHALL be fully symmetric read/write ports on one shared DEPTH x DATA_WIDTH array.
REQ-008 A write SHALL occur on the rising edge when port_en_x=1, wr_en_x=1 and busy=0.
REQ-009 A read (port_en_x=1, wr_en_x=0, busy=0) SHALL present mem[addr] on data_output_x one cycle after the sampling edge (latency 1).
REQ-010 When port_en_x=0 or busy=1, data_output_x SHALL hold its previous value.
REQ-011 During a write on port x, data_output_x SHALL load old mem[addr] if RDW_MODE=0 and data_in_x if RDW_MODE=1.
REQ-012 A cross-port read of an address written by the other port in the same cycle SHALL return the old data, in both modes.
REQ-013 When both ports write the same address in the same cycle, port 0 data SHALL be stored and collision SHALL be 1 for exactly the following cycle; otherwise collision=0.
REQ-014 Same-address dual reads SHALL both return the stored word without raising collision.
REQ-015 The clear sequencer SHALL have two states, IDLE and CLEAR, with an ADDR_WIDTH+1-bit clear counter.
REQ-016 In CLEAR, the sequencer SHALL write 0 to mem[counter] once per cycle, from address 0 up to DEPTH-1, then go to IDLE on the cycle after writing DEPTH-1.
REQ-017 busy SHALL equal 1 exactly while in CLEAR, i.e. for DEPTH cycles.
REQ-018 With CLEAR_ON_RESET=0, the sequencer SHALL stay in IDLE, busy SHALL stay 0, and memory contents SHALL be unaffected by reset.

Reset
REQ-019 While reset=1 at a rising edge, the block SHALL set data_output_0=0, data_output_1=0 and collision=0, and SHALL perform no user writes.
REQ-020 At that same edge, the block SHALL set the state to CLEAR with counter 0 if CLEAR_ON_RESET=1, else to IDLE.
REQ-021 Reset asserted mid-CLEAR SHALL restart the clear from address 0.
REQ-022 The first user access SHALL be accepted on the first edge at which busy=0.

Verification
REQ-023 Defaults; reset for 2 cycles, then release -> busy=1 for exactly 16 cycles; reading addresses 0..15 afterwards returns 0x00.
REQ-024 Port 0 writes data i+1 to addresses i=0..15, then port 1 reads addresses 0..15 -> data_output_1 = 0x01..0x10, each 1 cycle after its address.
REQ-025 Same cycle: port 0 writes 0xAA and port 1 writes 0x55, both to address 3 -> mem[3]=0xAA and collision=1 for one cycle; next cycle -> collision=0.
REQ-026 mem[5]=0x11; port 0 writes 0x22 to address 5 while port 1 reads address 5 -> data_output_1=0x11; RDW_MODE=0 -> data_output_0=0x11; RDW_MODE=1 -> data_output_0=0x22.
REQ-027 Reset pulse at clear cycle 7, then release -> busy stays high 16 further cycles; user write attempted while busy=1 is dropped and the location reads 0x00.
REQ-028 DATA_WIDTH=16, ADDR_WIDTH=6, CLEAR_ON_RESET=0 -> busy never asserts; write 0xBEEF to address 63 and read it back on port 1 -> 0xBEEF.
